// File: rtl/pack_pkg.sv
// pack_pkg: shared state encoding, lane type and word geometry for pack8to32.
package pack_pkg;
  localparam int BYTES_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, FILL, EMIT, FLUSH, DONE_BEAT} state_t;
  typedef logic [1:0] lane_t;
endpackage

// File: rtl/pack8to32.sv
// pack8to32: packs a byte stream into 32-bit words with a terminating done beat.
// Define PACK8TO32_BIG_ENDIAN_EN to put the first byte of each word in bits [31:24].
module pack8to32
  import pack_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic               _clock,
  input  logic               _reset_n,
  input  logic               _start,
  input  logic signed [31:0] _in0,
  input  logic               _in_valid,
  input  logic               _in_done,
  output logic               _in_ready,
  input  logic               _ready,
  output logic               _valid,
  output logic               _done,
  output logic signed [31:0] _out0,
  output logic [2:0]         _out1
);
  state_t      state_q, state_d;
  lane_t       lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        unused_in;
  assign unused_in = ^_in0[31:8];
  function automatic int lane_ofs(input lane_t l);
`ifdef PACK8TO32_BIG_ENDIAN_EN
    return (BYTES_PER_WORD - 1 - int'(l)) * 8;
`else
    return int'(l) * 8;
`endif
  endfunction
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    if (_start) begin
      state_d = FILL;
      lane_d  = '0;
      word_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FILL: if (_in_valid) begin
          if (_in_done) begin
            // lanes at or beyond the counter carry no data in a partial word
            for (int i = 0; i < BYTES_PER_WORD; i++)
              if (lane_q != '0 && i >= int'(lane_q)) word_d[lane_ofs(lane_t'(i)) +: 8] = PAD_BYTE;
            cnt_d   = {1'b0, lane_q};
            state_d = (lane_q == '0) ? DONE_BEAT : FLUSH;
            lane_d  = '0;
          end else begin
            word_d[lane_ofs(lane_q) +: 8] = _in0[7:0];
            lane_d = lane_q + 2'd1;
            if (lane_q == lane_t'(BYTES_PER_WORD - 1)) begin
              state_d = EMIT;
              cnt_d   = 3'(BYTES_PER_WORD);
            end
          end
        end
        EMIT: state_d = _ready ? FILL : EMIT;
        FLUSH: if (_ready) begin
          state_d = DONE_BEAT;
          cnt_d   = '0;
        end
        DONE_BEAT: state_d = _ready ? IDLE : DONE_BEAT;
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end
  assign _in_ready = state_q == FILL;
  assign _valid    = state_q == EMIT || state_q == FLUSH || state_q == DONE_BEAT;
  assign _done     = state_q == DONE_BEAT;
  assign _out0     = word_q;
  assign _out1     = cnt_q;
endmodule

// File: tb/tb_pack8to32.sv
// tb_pack8to32: scoreboard bench for pack8to32 with default and 8'hFF padding.
module tb_pack8to32;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0, in_done = 0, ready = 1, toggle = 0;
  logic signed [31:0] in0 = 0;
  logic in_ready_a, valid_a, done_a, in_ready_b, valid_b, done_b;
  logic signed [31:0] out0_a, out0_b;
  logic [2:0] out1_a, out1_b;
  typedef struct packed {logic [31:0] w; logic [2:0] n; logic d;} exp_t;
  exp_t qa[$], qb[$];
  exp_t e;
  int passed = 0, total = 0;
  logic pv_a = 0;
  logic [31:0] pw_a = 0;
  logic [3:0] pm_a = 0;

  always #5 clk = ~clk;

  pack8to32 dut_a (
    ._clock(clk), ._reset_n(rst_n), ._start(start), ._in0(in0), ._in_valid(in_valid),
    ._in_done(in_done), ._in_ready(in_ready_a), ._ready(ready), ._valid(valid_a),
    ._done(done_a), ._out0(out0_a), ._out1(out1_a));

  pack8to32 #(.PAD_BYTE(8'hFF)) dut_b (
    ._clock(clk), ._reset_n(rst_n), ._start(start), ._in0(in0), ._in_valid(in_valid),
    ._in_done(in_done), ._in_ready(in_ready_b), ._ready(ready), ._valid(valid_b),
    ._done(done_b), ._out0(out0_b), ._out1(out1_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic push2(input logic [31:0] wa, input logic [31:0] wb, input logic [2:0] n);
    qa.push_back({wa, n, 1'b0});
    qb.push_back({wb, n, 1'b0});
  endtask

  task automatic push_done();
    qa.push_back({32'h0, 3'd0, 1'b1});
    qb.push_back({32'h0, 3'd0, 1'b1});
  endtask

  task automatic start_run();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic beat(input logic [7:0] b, input logic d);
    bit got = 0;
    in0 = {24'hA5C3E1, b};
    in_done = d;
    in_valid = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = in_ready_a;
    end
    chk("accept_wait", 32'(got), 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
    in_done = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial forever begin
    @(posedge clk); #1;
    ready = toggle ? ~ready : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) pv_a <= 0;
    else begin
      if (pv_a) begin
        chk("hold_valid", 32'(valid_a), 32'd1);
        chk("hold_word", out0_a, pw_a);
        chk("hold_meta", 32'({out1_a, done_a}), 32'(pm_a));
      end
      if (valid_a && toggle) chk("in_ready_out", 32'(in_ready_a), 32'd0);
      if (valid_a && ready) begin
        if (qa.size() == 0) begin
          total++;
          $display("FAIL unexpected_a: got %h/%0d/%b want no beat", out0_a, out1_a, done_a);
        end else begin
          e = qa.pop_front();
          if (!e.d) chk("word_a", out0_a, e.w);
          chk("count_a", 32'(out1_a), 32'(e.n));
          chk("done_a", 32'(done_a), 32'(e.d));
        end
      end
      if (valid_b && ready) begin
        if (qb.size() == 0) begin
          total++;
          $display("FAIL unexpected_b: got %h/%0d/%b want no beat", out0_b, out1_b, done_b);
        end else begin
          e = qb.pop_front();
          if (!e.d) chk("word_b", out0_b, e.w);
          chk("count_b", 32'(out1_b), 32'(e.n));
          chk("done_b", 32'(done_b), 32'(e.d));
        end
      end
      pv_a <= valid_a && !ready;
      pw_a <= out0_a;
      pm_a <= {out1_a, done_a};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    chk("rst_out0", out0_a, 32'd0);
    chk("rst_out1_done", 32'({out1_a, done_a}), 32'd0);
    rst_n = 1;
    @(posedge clk); #1;

`ifdef PACK8TO32_BIG_ENDIAN_EN
    push2(32'h11223344, 32'h11223344, 3'd4);
`else
    push2(32'h44332211, 32'h44332211, 3'd4);
`endif
    push_done();
    start_run();
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    @(negedge clk);
    chk("latency_valid", 32'(valid_a), 32'd1);
    chk("latency_count", 32'(out1_a), 32'd4);
    beat(8'h00, 1);
    drain();

`ifdef PACK8TO32_BIG_ENDIAN_EN
    push2(32'h01020000, 32'h0102FFFF, 3'd2);
`else
    push2(32'h00000201, 32'hFFFF0201, 3'd2);
`endif
    push_done();
    start_run();
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h00, 1);
    drain();

    push_done();
    start_run();
    beat(8'h00, 1);
    drain();

    toggle = 1;
`ifdef PACK8TO32_BIG_ENDIAN_EN
    push2(32'h00010203, 32'h00010203, 3'd4);
    push2(32'h04050607, 32'h04050607, 3'd4);
`else
    push2(32'h03020100, 32'h03020100, 3'd4);
    push2(32'h07060504, 32'h07060504, 3'd4);
`endif
    push_done();
    start_run();
    for (int i = 0; i < 8; i++) beat(8'(i), 0);
    beat(8'h00, 1);
    drain();
    toggle = 0;
    @(posedge clk); #1;

    start_run();
    beat(8'h55, 0); beat(8'h66, 0);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_out0", out0_a, 32'd0);
    chk("mid_rst_out1_done", 32'({out1_a, done_a}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;
`ifdef PACK8TO32_BIG_ENDIAN_EN
    push2(32'hAABBCCDD, 32'hAABBCCDD, 3'd4);
`else
    push2(32'hDDCCBBAA, 32'hDDCCBBAA, 3'd4);
`endif
    push_done();
    start_run();
    beat(8'hAA, 0); beat(8'hBB, 0); beat(8'hCC, 0); beat(8'hDD, 0); beat(8'h00, 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
